// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV64I instruction encoder.
// Formats, opcode constants and the signed-immediate fit test used by the packer.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'd0,
    FMT_S = 2'd1,
    FMT_B = 2'd2,
    FMT_R = 2'd3
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // True when imm is the sign extension of its low (msb+1) bits.
  function automatic logic imm_fits(input logic [63:0] imm, input int unsigned msb);
    logic [63:0] upper;
    upper = 64'($signed(imm) >>> msb);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer for I/S/B/R formats plus immediate range check.
// CHECK_EN=0 makes every request legal, so immediates are silently truncated.
module instr_pack
  import instr_encoder_pkg::*;
#(
  parameter bit CHECK_EN = 1'b0
) (
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [63:0] imm,
  output logic [31:0] data,
  output logic        legal
);

  logic range_ok;

  // NOTE: every output of an always_comb gets a default first so no path infers a latch.
  always_comb begin
    data     = '0;
    range_ok = 1'b1;
    unique case (fmt)
      FMT_I: begin
        data     = {imm[11:0], rs1, funct3, rd, opcode};
        range_ok = imm_fits(imm, 11);
      end
      FMT_S: begin
        data     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_ok = imm_fits(imm, 11);
      end
      FMT_B: begin
        data     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_ok = imm_fits(imm, 12) && !imm[0];
      end
      FMT_R: begin
        data     = {funct7, rs2, rs1, funct3, rd, opcode};
        range_ok = 1'b1;
      end
      default: begin
        data     = '0;
        range_ok = 1'b1;
      end
    endcase
    legal = !CHECK_EN || range_ok;
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams packed RV64I words into instruction memory at auto-incrementing addresses.
// Define INSTR_ENCODER_RANGE_CHECK_EN to reject out-of-range immediates and drive err.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              err
);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       pack_data;
  logic              pack_legal;
  logic              accept;
  logic              write;
  logic              err_q;

  instr_pack #(.CHECK_EN(CHECK_EN)) u_pack (
    .fmt    (fmt_e'(in_fmt)),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .data   (pack_data),
    .legal  (pack_legal)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign write    = accept && pack_legal;

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (write) begin
      out_valid <= 1'b1;
      out_addr  <= clr ? BASE : next_addr;
      out_data  <= pack_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A request accepted alongside clr takes BASE and leaves BASE+4 behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr <= BASE;
    end else if (clr) begin
      next_addr <= write ? BASE + STEP : BASE;
    end else if (write) begin
      next_addr <= next_addr + STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (clr) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Setting the error wins over a concurrent clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && !pack_legal) begin
      err_q <= 1'b1;
    end else if (clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = CHECK_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing, range handling, backpressure, clr, wrap, reset.
// A second instance with ADDR_W=4 sees identical stimulus and exercises address wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [63:0] in_imm = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, err;
  logic [15:0] out_addr, word_cnt;
  logic [31:0] out_data;

  logic        b_in_ready, b_out_valid, b_err;
  logic [3:0]  b_out_addr, b_word_cnt;
  logic [31:0] b_out_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .word_cnt(word_cnt), .err(err)
  );

  instr_encoder #(.ADDR_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_addr(b_out_addr), .out_data(b_out_data), .word_cnt(b_word_cnt), .err(b_err)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so at negedge valid&&ready predicts the next beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) qa.push_back('{32'(out_addr), out_data});
    if (rst_n && b_out_valid && out_ready) qb.push_back('{32'(b_out_addr), b_out_data});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [63:0] imm);
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = 7'd0;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // Holds the current request until handshaken; returns at posedge+1.
  task automatic wait_accept(input string tag);
    logic rdy;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check({tag, "_timeout"}, 64'(rdy), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [1:0] f, input logic [6:0] op,
                      input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [63:0] imm);
    drive(f, op, f3, rd, rs1, rs2, imm);
    wait_accept(tag);
  endtask

  task automatic send_i(input logic [4:0] rd, input logic [63:0] imm);
    send("send_i", 2'd0, 7'b0010011, 3'd0, rd, 5'd0, 5'd0, imm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_qa(input string tag, input int idx, input logic [31:0] addr,
                           input logic [31:0] data);
    if (idx < qa.size()) begin
      check({tag, "_addr"}, 64'(qa[idx].addr), 64'(addr));
      check({tag, "_data"}, 64'(qa[idx].data), 64'(data));
    end
  endtask

  logic [31:0] held;
  logic [31:0] base4;

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Basic packing, all four at consecutive addresses
    send_i(5'd1, 64'd5);
    send_i(5'd2, -64'sd1);
    send("s", 2'd1, 7'b0100011, 3'b011, 5'd0, 5'd4, 5'd3, 64'd16);
    send("b", 2'd2, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 64'd8);
    idle(3);
    check("basic_count", 64'(qa.size()), 64'd4);
    expect_qa("i_pos", 0, 32'h0, 32'h00500093);
    expect_qa("i_neg", 1, 32'h4, 32'hFFF00113);
    expect_qa("s_fmt", 2, 32'h8, 32'h00323823);
    expect_qa("b_fmt", 3, 32'hC, 32'h00208463);
    check("basic_word_cnt", 64'(word_cnt), 64'd4);
    qa.delete();

    // Out-of-range immediates followed by a marker word
    send_i(5'd1, 64'd2048);
    send("b_odd", 2'd2, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 64'd3);
    send_i(5'd1, 64'd5);
    idle(3);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    check("range_count", 64'(qa.size()), 64'd1);
    expect_qa("range_marker", 0, 32'h10, 32'h00500093);
    check("range_err", 64'(err), 64'd1);
    base4 = 32'h14;
`else
    check("trunc_count", 64'(qa.size()), 64'd3);
    expect_qa("trunc_i", 0, 32'h10, 32'h80000093);
    expect_qa("trunc_b", 1, 32'h14, 32'h00208163);
    expect_qa("trunc_marker", 2, 32'h18, 32'h00500093);
    check("trunc_err", 64'(err), 64'd0);
    base4 = 32'h1C;
`endif
    qa.delete();

    // Backpressure: 3 stalled cycles with a second request pending
    out_ready = 1'b0;
    send_i(5'd1, 64'd1);
    held = 32'h00100093;
    drive(2'd0, 7'b0010011, 3'd0, 5'd2, 5'd0, 5'd0, 64'd2);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_data", 64'(out_data), 64'(held));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_accept("bp2");
    send_i(5'd3, 64'd3);
    send_i(5'd4, 64'd4);
    idle(3);
    check("bp_count", 64'(qa.size()), 64'd4);
    expect_qa("bp0", 0, base4,         32'h00100093);
    expect_qa("bp1", 1, base4 + 32'd4, 32'h00200113);
    expect_qa("bp2", 2, base4 + 32'd8, 32'h00300193);
    expect_qa("bp3", 3, base4 + 32'd12, 32'h00400213);
    qa.delete();

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // Illegal request concurrent with clr: set wins
    clr = 1'b1;
    drive(2'd0, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2048);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_vs_set_err", 64'(err), 64'd1);
`endif

    // clr with a simultaneous accept
    qb.delete();
    check("pre_clr_word_cnt_nz", 64'(word_cnt != 0), 64'd1);
    clr = 1'b1;
    drive(2'd0, 7'b0010011, 3'd0, 5'd5, 5'd0, 5'd0, 64'd5);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_out_valid", 64'(out_valid), 64'd1);
    check("clr_out_addr", 64'(out_addr), 64'd0);
    check("clr_out_data", 64'(out_data), 64'h00500293);
    check("clr_word_cnt0", 64'(word_cnt), 64'd0);
    check("clr_err", 64'(err), 64'd0);
    idle(1);
    check("clr_word_cnt1", 64'(word_cnt), 64'd1);
    send_i(5'd6, 64'd6);
    send_i(5'd7, 64'd7);
    send_i(5'd8, 64'd8);
    send_i(5'd9, 64'd9);
    idle(3);
    check("post_clr_count", 64'(qa.size()), 64'd5);
    expect_qa("post_clr0", 0, 32'h0,  32'h00500293);
    expect_qa("post_clr1", 1, 32'h4,  32'h00600313);
    expect_qa("post_clr4", 4, 32'h10, 32'h00900493);
    check("post_clr_word_cnt", 64'(word_cnt), 64'd5);

    // Narrow instance wraps to 0, not to BASE_ADDR
    check("wrap_count", 64'(qb.size()), 64'd5);
    for (int i = 0; i < 5 && i < qb.size(); i++)
      check($sformatf("wrap_addr%0d", i), 64'(qb[i].addr), 64'((i * 4) % 16));

    // Async reset in the middle of a stall
    out_ready = 1'b0;
    send_i(5'd1, 64'd1);
    drive(2'd0, 7'b0010011, 3'd0, 5'd2, 5'd0, 5'd0, 64'd2);
    @(posedge clk); #3;
    check("stall_before_rst", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_addr", 64'(out_addr), 64'd0);
    check("arst_word_cnt", 64'(word_cnt), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
